// File: rtl/alarm_trigger.sv
// Alarm comparator and buzzer sequencer: rings on entry to the alarm minute,
// with stop, limited snooze and auto-timeout after RING_SECS seconds.
//
// state   | meaning
// IDLE    | waiting for the time to enter the alarm minute
// RINGING | buzzer toggling once per second until stop, snooze or timeout
// SNOOZE  | buzzer silent, counting down to the next ring
module alarm_trigger #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [3:0] t_h1,
  input  logic [3:0] t_h0,
  input  logic [3:0] t_m1,
  input  logic [3:0] t_m0,
  input  logic [3:0] a_h1,
  input  logic [3:0] a_h0,
  input  logic [3:0] a_m1,
  input  logic [3:0] a_m0,
  input  logic       alarm_en,
  input  logic       push_stop,
  input  logic       push_snooze,
  output logic       buzz,
  output logic       ringing,
  output logic       snoozing,
  output logic [3:0] snooze_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RINGING = 2'd1;
  localparam logic [1:0] SNOOZE  = 2'd2;

  localparam logic [9:0] RING_LAST   = 10'(RING_SECS - 1);
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
  localparam logic [3:0] SNOOZE_MAX  = 4'(MAX_SNOOZE);

  logic [1:0] state, state_n;
  logic [9:0] ring_cnt, ring_cnt_n;
  logic [9:0] snooze_cnt, snooze_cnt_n;
  logic [3:0] snooze_count_n;
  logic       buzz_n;

  logic match, match_q, match_rise;
  logic stop_s1, stop_s2, stop_prev;
  logic snz_s1, snz_s2, snz_prev;
  logic stop_ev, snz_ev;

  assign match = alarm_en &
                 (t_h1 == a_h1) & (t_h0 == a_h0) &
                 (t_m1 == a_m1) & (t_m0 == a_m0);
  assign match_rise = match & ~match_q;

  // match_q resets high so a time already equal to the alarm at reset release
  // does not count as entering the alarm minute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q   <= 1'b1;
      stop_s1   <= 1'b1;
      stop_s2   <= 1'b1;
      stop_prev <= 1'b1;
      snz_s1    <= 1'b1;
      snz_s2    <= 1'b1;
      snz_prev  <= 1'b1;
    end else begin
      match_q   <= match;
      stop_s1   <= push_stop;
      stop_s2   <= stop_s1;
      stop_prev <= stop_s2;
      snz_s1    <= push_snooze;
      snz_s2    <= snz_s1;
      snz_prev  <= snz_s2;
    end
  end

  assign stop_ev = stop_prev & ~stop_s2;
  assign snz_ev  = snz_prev & ~snz_s2;

  always_comb begin
    state_n        = state;
    buzz_n         = buzz;
    ring_cnt_n     = ring_cnt;
    snooze_cnt_n   = snooze_cnt;
    snooze_count_n = snooze_count;
    if (!alarm_en) begin
      state_n = IDLE;
      buzz_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          buzz_n = 1'b0;
          if (match_rise) begin
            state_n        = RINGING;
            ring_cnt_n     = 10'd0;
            buzz_n         = 1'b1;
            snooze_count_n = 4'd0;
          end
        end
        RINGING: begin
          if (stop_ev) begin
            state_n = IDLE;
            buzz_n  = 1'b0;
          end else if (snz_ev && (snooze_count < SNOOZE_MAX)) begin
            state_n        = SNOOZE;
            snooze_cnt_n   = 10'd0;
            snooze_count_n = snooze_count + 4'd1;
            buzz_n         = 1'b0;
          end else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state_n = IDLE;
              buzz_n  = 1'b0;
            end else begin
              buzz_n     = ~buzz;
              ring_cnt_n = ring_cnt + 10'd1;
            end
          end
        end
        SNOOZE: begin
          buzz_n = 1'b0;
          if (stop_ev) begin
            state_n = IDLE;
          end else if (sec_tick) begin
            if (snooze_cnt == SNOOZE_LAST) begin
              state_n    = RINGING;
              ring_cnt_n = 10'd0;
              buzz_n     = 1'b1;
            end else begin
              snooze_cnt_n = snooze_cnt + 10'd1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          buzz_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      buzz         <= 1'b0;
      ring_cnt     <= 10'd0;
      snooze_cnt   <= 10'd0;
      snooze_count <= 4'd0;
      ringing      <= 1'b0;
      snoozing     <= 1'b0;
    end else begin
      state        <= state_n;
      buzz         <= buzz_n;
      ring_cnt     <= ring_cnt_n;
      snooze_cnt   <= snooze_cnt_n;
      snooze_count <= snooze_count_n;
      ringing      <= (state_n == RINGING);
      snoozing     <= (state_n == SNOOZE);
    end
  end

endmodule
